// File: rtl/mips_multi_cycle.sv
// mips_multi_cycle: multi-cycle MIPS-subset core with a unified memory port and debug visibility
module mips_multi_cycle #(
  parameter int ADDR_W = 8,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  input  logic [4:0]        dbg_ra,
  output logic [31:0]       dbg_rd,
  input  logic [2:0]        i_sel,
  output logic [31:0]       o_sel_data,
  output logic [3:0]        state,
  output logic              instr_done
);
  typedef enum logic [3:0] {
    IF_S, ID_S, EX_R, WB_R, EX_I, WB_I, EX_ADDR, MEM_RD, WB_MEM, MEM_WR, BR, JMP
  } st_t;
  st_t st, id_next;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, rf_wa;
  logic [31:0] simm, ra_v, rb_v, alu_r, rf_wd;
  logic r_ok, rf_we;
  assign op = ir[31:26];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign funct = ir[5:0];
  assign simm = {{16{ir[15]}}, ir[15:0]};
  assign ra_v = rs == 5'd0 ? 32'd0 : rf[rs];
  assign rb_v = rt == 5'd0 ? 32'd0 : rf[rt];
  assign r_ok = op == 6'h00 && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                                funct == 6'h25 || funct == 6'h2A);
  always_comb begin
    id_next = r_ok ? EX_R : op == 6'h08 ? EX_I : (op == 6'h23 || op == 6'h2B) ? EX_ADDR :
              (op == 6'h04 || op == 6'h05) ? BR : op == 6'h02 ? JMP : IF_S;
    alu_r = funct == 6'h22 ? a - b : funct == 6'h24 ? a & b : funct == 6'h25 ? a | b :
            funct == 6'h2A ? {31'd0, $signed(a) < $signed(b)} : a + b;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PC_RESET;
      ir <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
      mdr <= '0;
      st <= IF_S;
    end else begin
      case (st)
        IF_S: begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
          st <= ID_S;
        end
        ID_S: begin
          a <= ra_v;
          b <= rb_v;
          alu_out <= pc + {simm[29:0], 2'b00};
          st <= id_next;
        end
        EX_R: begin
          alu_out <= alu_r;
          st <= WB_R;
        end
        EX_I: begin
          alu_out <= a + simm;
          st <= WB_I;
        end
        EX_ADDR: begin
          alu_out <= a + simm;
          st <= op == 6'h23 ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          mdr <= mem_rdata;
          st <= WB_MEM;
        end
        BR: begin
          if ((a == b) == (op == 6'h04)) pc <= alu_out;
          st <= IF_S;
        end
        JMP: begin
          pc <= {pc[31:28], ir[25:0], 2'b00};
          st <= IF_S;
        end
        default: st <= IF_S;
      endcase
    end
  end
  assign rf_we = st == WB_R || st == WB_I || st == WB_MEM;
  assign rf_wa = st == WB_R ? rd : rt;
  assign rf_wd = st == WB_MEM ? mdr : alu_out;
  always_ff @(posedge clk) begin
    if (!rst && rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
  end
  assign mem_addr = st == IF_S ? pc[ADDR_W+1:2] : alu_out[ADDR_W+1:2];
  assign mem_wdata = b;
  assign mem_we = st == MEM_WR && !rst;
  assign instr_done = st == WB_R || st == WB_I || st == WB_MEM || st == MEM_WR || st == BR ||
                      st == JMP || (st == ID_S && id_next == IF_S);
  assign state = st;
  assign dbg_rd = dbg_ra == 5'd0 ? 32'd0 : rf[dbg_ra];
  always_comb
    o_sel_data = i_sel == 3'd0 ? pc : i_sel == 3'd1 ? ir : i_sel == 3'd2 ? a :
                 i_sel == 3'd3 ? b : i_sel == 3'd4 ? alu_out : i_sel == 3'd5 ? mdr :
                 i_sel == 3'd6 ? 32'(mem_addr) : {28'd0, st};
endmodule

// File: tb/tb_mips_multi_cycle.sv
// tb_mips_multi_cycle: instruction-level reference model plus directed and random programs
module tb_mips_multi_cycle;
  localparam int AW = 8;
  localparam logic [31:0] PCR = 32'h0000_0000;
  logic clk = 0, rst = 1;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, dbg_rd, o_sel_data;
  logic mem_we, instr_done;
  logic [4:0] dbg_ra = 0;
  logic [2:0] i_sel = 0;
  logic [3:0] state;
  int checks = 0, errors = 0;
  logic [31:0] mem [256];
  logic [31:0] m_mem [256];
  logic [31:0] m_rf [32];
  logic m_rfv [32];
  logic [31:0] m_pc;
  int cyc = 1;
  logic m_ok = 0;
  int lat_tab [7] = '{2, 4, 4, 5, 4, 3, 3};

  mips_multi_cycle #(.ADDR_W(AW), .PC_RESET(PCR)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .dbg_ra(dbg_ra), .dbg_rd(dbg_rd), .i_sel(i_sel),
    .o_sel_data(o_sel_data), .state(state), .instr_done(instr_done)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] = mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input logic [15:0] i);
    return {{16{i[15]}}, i};
  endfunction

  // 0 unsupported, 1 R-type, 2 addi, 3 lw, 4 sw, 5 beq/bne, 6 j
  function automatic int kind_of(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) ? 1 : 0;
    case (op)
      6'h08: return 2;
      6'h23: return 3;
      6'h2B: return 4;
      6'h04, 6'h05: return 5;
      6'h02: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] exp_state(input int k, input int c);
    if (c == 1) return 4'd0;
    if (c == 2) return 4'd1;
    case (k)
      1: return c == 3 ? 4'd2 : 4'd3;
      2: return c == 3 ? 4'd4 : 4'd5;
      3: return c == 3 ? 4'd6 : c == 4 ? 4'd7 : 4'd8;
      4: return c == 3 ? 4'd6 : 4'd9;
      5: return 4'd10;
      default: return 4'd11;
    endcase
  endfunction

  // Reference model: advances one instruction at a time, applying its effects on retirement
  always @(posedge clk) begin
    logic [31:0] ins, va, vb, ea, pc4, res;
    logic [4:0] rs, rt, d;
    logic ok, wr;
    int k;
    if (rst) begin
      m_ok = 1;
      m_pc = PCR;
      cyc = 1;
    end else if (m_ok) begin
      ins = m_mem[m_pc[AW+1:2]];
      k = kind_of(ins);
      if (cyc == lat_tab[k]) begin
        rs = ins[25:21];
        rt = ins[20:16];
        va = rs == 0 ? 32'd0 : m_rf[rs];
        vb = rt == 0 ? 32'd0 : m_rf[rt];
        ea = va + sx(ins[15:0]);
        pc4 = m_pc + 32'd4;
        m_pc = pc4;
        wr = 0;
        d = rt;
        res = 0;
        ok = 1;
        case (k)
          1: begin
            wr = 1;
            d = ins[15:11];
            ok = (rs == 0 || m_rfv[rs]) && (rt == 0 || m_rfv[rt]);
            case (ins[5:0])
              6'h20: res = va + vb;
              6'h22: res = va - vb;
              6'h24: res = va & vb;
              6'h25: res = va | vb;
              default: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
            endcase
          end
          2: begin
            wr = 1;
            res = ea;
            ok = rs == 0 || m_rfv[rs];
          end
          3: begin
            wr = 1;
            res = m_mem[ea[AW+1:2]];
          end
          4: m_mem[ea[AW+1:2]] = vb;
          5: if ((va == vb) == (ins[31:26] == 6'h04)) m_pc = pc4 + {sx(ins[15:0]), 2'b00};
          6: m_pc = {pc4[31:28], ins[25:0], 2'b00};
          default: ;
        endcase
        if (wr && d != 0) begin
          m_rf[d] = res;
          m_rfv[d] = ok;
        end
        cyc = 1;
      end else cyc++;
    end
  end

  always @(negedge clk) begin
    logic [31:0] ins, va, vb, ea;
    logic [4:0] rs, rt;
    logic va_ok, vb_ok;
    int k, lat;
    if (rst) chk("we_in_reset", 32'(mem_we), 32'd0);
    else if (m_ok) begin
      ins = m_mem[m_pc[AW+1:2]];
      k = kind_of(ins);
      lat = lat_tab[k];
      rs = ins[25:21];
      rt = ins[20:16];
      va = rs == 0 ? 32'd0 : m_rf[rs];
      vb = rt == 0 ? 32'd0 : m_rf[rt];
      va_ok = rs == 0 || m_rfv[rs];
      vb_ok = rt == 0 || m_rfv[rt];
      ea = va + sx(ins[15:0]);
      chk("state", 32'(state), 32'(exp_state(k, cyc)));
      chk("instr_done", 32'(instr_done), 32'(cyc == lat));
      chk("mem_we", 32'(mem_we), 32'(k == 4 && cyc == lat));
      if (cyc == 1) chk("fetch_addr", 32'(mem_addr), 32'(m_pc[AW+1:2]));
      if (cyc == 4 && (k == 3 || k == 4) && va_ok) chk("data_addr", 32'(mem_addr), 32'(ea[AW+1:2]));
      if (cyc == 4 && k == 4 && vb_ok) chk("mem_wdata", mem_wdata, vb);
      case (i_sel)
        3'd0: chk("sel_pc", o_sel_data, cyc == 1 ? m_pc : m_pc + 32'd4);
        3'd1: if (cyc >= 2) chk("sel_ir", o_sel_data, ins);
        3'd2: if (cyc >= 3 && va_ok) chk("sel_a", o_sel_data, va);
        3'd3: if (cyc >= 3 && vb_ok) chk("sel_b", o_sel_data, vb);
        3'd4: if (cyc == 3) chk("sel_aluout", o_sel_data, m_pc + 32'd4 + {sx(ins[15:0]), 2'b00});
        3'd5: if (k == 3 && cyc == 5 && va_ok) chk("sel_mdr", o_sel_data, m_mem[ea[AW+1:2]]);
        3'd6: if (cyc == 1) chk("sel_addr", o_sel_data, 32'(m_pc[AW+1:2]));
        default: chk("sel_state", o_sel_data, 32'(exp_state(k, cyc)));
      endcase
      if (dbg_ra == 0 || m_rfv[dbg_ra]) chk("dbg_rd", dbg_rd, dbg_ra == 0 ? 32'd0 : m_rf[dbg_ra]);
    end
  end

  function automatic logic [31:0] rnd_ins();
    logic [5:0] fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] op [4] = '{6'h08, 6'h23, 6'h2B, 6'h04};
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, fn[$urandom_range(0, 4)]};
    if (r < 7) return {op[r - 3], 5'($urandom), 5'($urandom), 16'($urandom)};
    if (r == 7) return {6'h05, 5'($urandom), 5'($urandom), 16'($urandom_range(0, 16)) - 16'd8};
    if (r == 8) return {6'h02, 26'($urandom)};
    return $urandom;
  endfunction

  task automatic load(input int i, input logic [31:0] v);
    mem[i] = v;
    m_mem[i] = v;
  endtask

  initial begin
    logic [31:0] pc_at [1:46];
    logic [AW-1:0] ad_at [1:46];
    logic [31:0] wd_at [1:46];
    logic [3:0] st_at [1:46];
    logic we_at [1:46];
    int dq [$];
    int exp_done [13] = '{4, 8, 12, 16, 20, 25, 28, 32, 34, 37, 40, 43, 46};
    int wes, bad;
    for (int i = 0; i < 32; i++) m_rfv[i] = 0;
    for (int i = 0; i < 256; i++) load(i, 32'd0);
    load(0, 32'h2001_0005);
    load(1, 32'h2002_FFFD);
    load(2, 32'h0022_1820);
    load(3, 32'h0041_202A);
    load(4, 32'hAC01_0008);
    load(5, 32'h8C05_0008);
    load(6, 32'h1421_0004);
    load(7, 32'h2000_0007);
    load(8, 32'hFC00_0000);
    load(9, 32'h0BFF_FFFF);
    load(12, 32'h1021_FFFF);
    load(255, 32'h0800_000C);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int n = 1; n <= 46; n++) begin
      @(negedge clk);
      pc_at[n] = o_sel_data;
      ad_at[n] = mem_addr;
      wd_at[n] = mem_wdata;
      st_at[n] = state;
      we_at[n] = mem_we;
      if (instr_done) dq.push_back(n);
    end
    chk("reset_pc", pc_at[1], PCR);
    chk("reset_state", 32'(st_at[1]), 32'd0);
    chk("reset_fetch", 32'(ad_at[1]), 32'd0);
    chk("done_count", dq.size(), 13);
    for (int i = 0; i < dq.size() && i < 13; i++) chk("done_cycle", dq[i], exp_done[i]);
    wes = 0;
    for (int n = 1; n <= 46; n++) wes += int'(we_at[n]);
    chk("we_pulses", wes, 1);
    chk("sw_we", 32'(we_at[20]), 32'd1);
    chk("sw_addr", 32'(ad_at[20]), 32'd2);
    chk("sw_data", wd_at[20], 32'd5);
    chk("bne_fallthru", pc_at[29], 32'h0000_001C);
    chk("j_pc", pc_at[38], 32'h0FFF_FFFC);
    chk("j_wrap_addr", 32'(ad_at[38]), 32'hFF);
    chk("beq_loop1", pc_at[41], 32'h1000_0030);
    chk("beq_loop2", pc_at[44], 32'h1000_0030);
    chk("mem_word2", mem[2], 32'd5);
    foreach (exp_done[i]) begin
      case (i)
        0: dbg_ra = 3;
        1: dbg_ra = 4;
        2: dbg_ra = 5;
        default: dbg_ra = 0;
      endcase
      #1;
      if (i < 4) chk("reg_value", dbg_rd, i == 0 ? 32'd2 : i == 1 ? 32'd1 : i == 2 ? 32'd5 : 32'd0);
    end
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 load(0, 32'hAC01_0040);
    load(16, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 rst = 0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("abort_state", 32'(state), 32'd9);
    chk("abort_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1 chk("abort_mem", mem[16], 32'hDEAD_BEEF);
    for (int i = 0; i < 31; i++) load(i, {6'h08, 5'd0, 5'(i + 1), 16'($urandom)});
    for (int i = 31; i < 256; i++) load(i, rnd_ins());
    @(posedge clk);
    #1 rst = 0;
    repeat (6000) begin
      @(posedge clk);
      #1;
      i_sel = 3'($urandom);
      dbg_ra = 5'($urandom);
      rst = $urandom_range(0, 399) == 0;
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) bad++;
    chk("mem_image", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
